// File: rtl/oseq_pkg.sv
// Shared definitions for the Orion sequence fill engine: FSM encodings,
// mode constants and the default LFSR polynomial/seed.
package oseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_APPEND = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, Galois (right-shift) form
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hBEEF;

endpackage

// File: rtl/oseq_lfsr.sv
// Galois LFSR. A load of zero would lock the register up, so it is
// replaced by the non-zero fallback seed.
module oseq_lfsr
    import oseq_pkg::*;
#(
    parameter int                W    = 16,
    parameter logic [W-1:0]      TAPS = DEFAULT_TAPS,
    parameter logic [W-1:0]      SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    logic [W-1:0] state_reg;

    // Load has priority over stepping; one shift per step request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_reg <= state_reg[0] ? ((state_reg >> 1) ^ TAPS) : (state_reg >> 1);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/oseq_fill_engine.sv
// Sequence generator: writes LFSR-derived symbols into the sequence RAM,
// either a fresh FILL from address 0 or a single APPEND at the tail.
module oseq_fill_engine
    import oseq_pkg::*;
#(
    parameter int                 DW     = 4,
    parameter int                 AW     = 5,
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  TAPS   = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0]  SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [AW:0]       len,
    input  logic              abort,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [AW:0]       seq_len
);

    localparam int          SLICES    = LFSR_W / DW;
    localparam int          IW        = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(1) << AW;

    state_t            state_reg, state_next;
    logic              mode_reg;
    logic [AW:0]       eff_len_reg;
    logic [AW:0]       cnt_reg;
    logic [AW:0]       seq_len_reg;
    logic [AW-1:0]     addr_reg;
    logic [IW-1:0]     idx_reg;
    logic              wr_en_reg;
    logic [AW-1:0]     wr_addr_reg;
    logic [DW-1:0]     wr_data_reg;
    logic [LFSR_W-1:0] lfsr_state;
    logic [DW-1:0]     slice_arr [SLICES];

    logic in_idle, take_start, load_seed, commit, last_sym, idx_wrap;

    assign in_idle    = (state_reg == ST_IDLE);
    assign load_seed  = in_idle && seed_load;
    assign take_start = in_idle && start && !seed_load && !abort;
    assign commit     = (state_reg == ST_WRITE) && wr_ready && !abort;
    assign idx_wrap   = (idx_reg == IW'(SLICES - 1));
    assign last_sym   = (mode_reg == MODE_APPEND) || ((cnt_reg + (AW+1)'(1)) == eff_len_reg);
    assign full       = (seq_len_reg == DEPTH_LEN);

    // Split the LFSR state into DW-wide symbols, slice 0 in the low bits
    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slice_arr[gi] = lfsr_state[gi*DW +: DW];
        end
    endgenerate

    oseq_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (commit && idx_wrap),
        .load     (load_seed),
        .load_val (seed_val),
        .state    (lfsr_state)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic and status decode
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (take_start)
                    state_next = (mode == MODE_APPEND && full) ? ST_DONE : ST_GEN;
            end
            ST_GEN: begin
                busy       = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy = 1'b1;
                if (commit)
                    state_next = last_sym ? ST_DONE : ST_GEN;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort)
            state_next = ST_IDLE;
    end

    // Operation capture, slice index, address and length bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg    <= MODE_FILL;
            eff_len_reg <= '0;
            cnt_reg     <= '0;
            seq_len_reg <= '0;
            addr_reg    <= '0;
            idx_reg     <= '0;
        end else if (take_start) begin
            mode_reg    <= mode;
            eff_len_reg <= (len == '0 || len > DEPTH_LEN) ? DEPTH_LEN : len;
            cnt_reg     <= '0;
            addr_reg    <= (mode == MODE_APPEND) ? seq_len_reg[AW-1:0] : '0;
        end else if (commit) begin
            cnt_reg  <= cnt_reg + (AW+1)'(1);
            addr_reg <= addr_reg + AW'(1);
            idx_reg  <= idx_wrap ? '0 : idx_reg + IW'(1);
            if (last_sym)
                seq_len_reg <= (mode_reg == MODE_APPEND) ? seq_len_reg + (AW+1)'(1) : eff_len_reg;
        end
    end

    // Registered write port: strobe raised in GEN, held through WRITE until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else if (abort) begin
            wr_en_reg <= 1'b0;
        end else if (state_reg == ST_GEN) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= addr_reg;
            wr_data_reg <= slice_arr[idx_reg];
        end else if (commit) begin
            wr_en_reg <= 1'b0;
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign seq_len = seq_len_reg;

endmodule

// File: tb/tb_oseq_fill_engine.sv
// Directed bench for oseq_fill_engine: FILL, APPEND, backpressure, abort,
// seed reload and asynchronous reset, checked against hand-worked symbols.
module tb_oseq_fill_engine;

    localparam int DW = 4;
    localparam int AW = 5;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          seed_load = 1'b0;
    logic [LW-1:0] seed_val = '0;
    logic          wr_ready = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   seq_len;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];

    oseq_fill_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .abort     (abort),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .seq_len   (seq_len)
    );

    always #5 clk = ~clk;

    // RAM-side view: record every accepted write and every done pulse
    always @(posedge clk) begin
        if (wr_en && wr_ready) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            $display("write addr=%0d data=%0h", wr_addr, wr_data);
        end
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic expect_write(input string tag, input int i, input logic [31:0] ea, input logic [31:0] ed);
        if (i < log_addr.size()) begin
            check({tag, "_addr"}, 32'(log_addr[i]), ea);
            check({tag, "_data"}, 32'(log_data[i]), ed);
        end else begin
            check({tag, "_missing"}, 32'(log_addr.size()), 32'(i + 1));
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start(input logic m, input logic [AW:0] l);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [15:0] gstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    initial begin
        logic [15:0] m;
        int mi;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_seq_len", 32'(seq_len), 32'd0);
        check("rst_addr",    32'(wr_addr), 32'd0);
        check("rst_data",    32'(wr_data), 32'd0);
        rst = 1'b1;

        // FILL len=4 with the RAM always ready
        wr_ready = 1'b1;
        clear_log();
        do_start(1'b0, 6'd4);
        check("fill4_busy", 32'(busy), 32'd1);
        wait_done("fill4", 40);
        check("fill4_cnt", 32'(log_addr.size()), 32'd4);
        expect_write("fill4_w0", 0, 0, 32'hF);
        expect_write("fill4_w1", 1, 1, 32'hE);
        expect_write("fill4_w2", 2, 2, 32'hE);
        expect_write("fill4_w3", 3, 3, 32'hB);
        check("fill4_seq_len", 32'(seq_len), 32'd4);
        check("fill4_done_cnt", 32'(done_cnt), 32'd1);
        check("fill4_full", 32'(full), 32'd0);

        // Three APPENDs draw on the stepped LFSR (0xEB77)
        clear_log();
        for (int k = 0; k < 3; k++) begin
            do_start(1'b1, 6'd0);
            wait_done("app", 40);
        end
        check("app_cnt", 32'(log_addr.size()), 32'd3);
        expect_write("app_w0", 0, 4, 32'h7);
        expect_write("app_w1", 1, 5, 32'h7);
        expect_write("app_w2", 2, 6, 32'hB);
        check("app_seq_len", 32'(seq_len), 32'd7);
        check("app_done_cnt", 32'(done_cnt), 32'd3);

        // FILL len=0 means the whole RAM
        do_reset();
        clear_log();
        do_start(1'b0, 6'd0);
        wait_done("fill0", 200);
        check("fill0_cnt", 32'(log_addr.size()), 32'd32);
        m  = 16'hBEEF;
        mi = 0;
        for (int i = 0; i < 32; i++) begin
            expect_write("fill0_w", i, 32'(i), 32'(m[mi*4 +: 4]));
            mi++;
            if (mi == 4) begin
                mi = 0;
                m  = gstep(m);
            end
        end
        check("fill0_full", 32'(full), 32'd1);
        check("fill0_seq_len", 32'(seq_len), 32'd32);
        check("fill0_done_cnt", 32'(done_cnt), 32'd1);

        // APPEND when full: done but no write
        clear_log();
        do_start(1'b1, 6'd0);
        wait_done("appfull", 10);
        check("appfull_writes", 32'(log_addr.size()), 32'd0);
        check("appfull_seq_len", 32'(seq_len), 32'd32);
        check("appfull_done_cnt", 32'(done_cnt), 32'd1);

        // Next symbol comes from the LFSR after 8 steps
        clear_log();
        do_start(1'b0, 6'd1);
        wait_done("after32", 20);
        expect_write("after32_w0", 0, 0, 32'(m[3:0]));
        check("after32_seq_len", 32'(seq_len), 32'd1);

        // Backpressure: stall 5 cycles on address 1
        do_reset();
        clear_log();
        wr_ready = 1'b0;
        do_start(1'b0, 6'd4);
        @(negedge clk);
        check("bp_w0_en", 32'(wr_en), 32'd1);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_en",   32'(wr_en),   32'd1);
            check("bp_hold_addr", 32'(wr_addr), 32'd1);
            check("bp_hold_data", 32'(wr_data), 32'hE);
            @(negedge clk);
        end
        wr_ready = 1'b1;
        wait_done("bp", 40);
        check("bp_cnt", 32'(log_addr.size()), 32'd4);
        expect_write("bp_w0", 0, 0, 32'hF);
        expect_write("bp_w1", 1, 1, 32'hE);
        expect_write("bp_w2", 2, 2, 32'hE);
        expect_write("bp_w3", 3, 3, 32'hB);

        // Abort a FILL of 8 after the third commit
        clear_log();
        do_start(1'b0, 6'd8);
        n = 0;
        while (log_addr.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach3", 32'(log_addr.size()), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_wr_en", 32'(wr_en), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_cnt", 32'(log_addr.size()), 32'd3);
        expect_write("abort_w0", 0, 0, 32'h7);
        expect_write("abort_w1", 1, 1, 32'h7);
        expect_write("abort_w2", 2, 2, 32'hB);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_seq_len", 32'(seq_len), 32'd4);

        // Seed load of zero restores 0xBEEF; simultaneous start is dropped
        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = '0;
        start     = 1'b1;
        mode      = 1'b0;
        len       = 6'd2;
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b0;
        check("seed_start_ignored", 32'(busy), 32'd0);
        clear_log();
        do_start(1'b0, 6'd2);
        wait_done("seed", 20);
        check("seed_cnt", 32'(log_addr.size()), 32'd2);
        expect_write("seed_w0", 0, 0, 32'hB);
        expect_write("seed_w1", 1, 1, 32'h7);
        check("seed_seq_len", 32'(seq_len), 32'd2);

        // Asynchronous reset while a write is stalled
        clear_log();
        wr_ready = 1'b0;
        do_start(1'b0, 6'd4);
        @(negedge clk);
        check("arst_pre_en", 32'(wr_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_wr_en",   32'(wr_en),   32'd0);
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_data",    32'(wr_data), 32'd0);
        check("arst_seq_len", 32'(seq_len), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wr_ready = 1'b1;
        clear_log();
        do_start(1'b0, 6'd1);
        wait_done("arst", 20);
        check("arst_cnt", 32'(log_addr.size()), 32'd1);
        expect_write("arst_w0", 0, 0, 32'hF);
        check("arst_seq_len_after", 32'(seq_len), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
